// File: rtl/clkgen_freq_ctrl_if.sv
// Request/acknowledge channel between the control FSM (master) and the PLL
// clock-generator sequencer (slave).
interface clkgen_freq_ctrl_if;
  logic       req;
  logic [1:0] req_sel;
  logic       ack;
  logic       nack;
  logic       busy;

  modport master (output req, req_sel, input ack, nack, busy);
  modport slave  (input req, req_sel, output ack, nack, busy);
endinterface

// File: rtl/clkgen_freq_ctrl.sv
// PLL clock-generator sequencer: resets the PLL, qualifies lock, gates the
// downstream clock and steers the output mux on a frequency change.
module clkgen_freq_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter logic [1:0]  DEFAULT_SEL   = 2'd0
) (
  input  logic               clk_in,
  input  logic               reset_n,
  clkgen_freq_ctrl_if.slave  req_if,
  output logic [1:0]         cur_sel,
  output logic [1:0]         mux_sel,
  output logic               clk_en,
  output logic               pll_reset,
  input  logic               pll_locked,
  output logic               err,
  output logic               lock_lost
);

  localparam int unsigned QUIESCE_CYCLES = 4;
  localparam int unsigned SWITCH_CYCLES  = 2;
  localparam int unsigned MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  localparam int          RW      = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_PLLRST, S_WAIT_LOCK, S_SETTLE, S_SWITCH, S_ENABLE, S_FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic [1:0]    target;
  logic          ack_en;     // boot and lock-loss recovery complete silently
  logic          lk_meta;
  logic          lk_s;

  // NOTE: pll_locked comes from another clock domain; only lk_s may be used.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // sees the values from the start of the cycle.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_PLLRST;
      cnt         <= '0;
      retry       <= '0;
      target      <= DEFAULT_SEL;
      ack_en      <= 1'b0;
      pll_reset   <= 1'b1;
      clk_en      <= 1'b0;
      err         <= 1'b0;
      lock_lost   <= 1'b0;
      mux_sel     <= DEFAULT_SEL;
      cur_sel     <= DEFAULT_SEL;
      req_if.busy <= 1'b1;
      req_if.ack  <= 1'b0;
      req_if.nack <= 1'b0;
    end else begin
      req_if.ack  <= 1'b0;
      req_if.nack <= 1'b0;
      cnt         <= cnt + CW'(1);
      case (state)
        S_IDLE: begin
          if (!lk_s) begin
            clk_en      <= 1'b0;
            lock_lost   <= 1'b1;
            req_if.busy <= 1'b1;
            pll_reset   <= 1'b1;
            target      <= cur_sel;
            ack_en      <= 1'b0;
            cnt         <= '0;
            state       <= S_PLLRST;
          end else if (req_if.req) begin
            if (req_if.req_sel == 2'd3) begin
              req_if.nack <= 1'b1;
            end else if (req_if.req_sel == cur_sel) begin
              req_if.ack <= 1'b1;
            end else begin
              target      <= req_if.req_sel;
              ack_en      <= 1'b1;
              req_if.busy <= 1'b1;
              clk_en      <= 1'b0;
              cnt         <= '0;
              state       <= S_QUIESCE;
            end
          end
        end
        S_QUIESCE: begin
          if (cnt == CW'(QUIESCE_CYCLES - 1)) begin
            cnt       <= '0;
            pll_reset <= 1'b1;
            state     <= S_PLLRST;
          end
        end
        S_PLLRST: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            cnt       <= '0;
            pll_reset <= 1'b0;
            state     <= S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          if (lk_s) begin
            cnt   <= '0;
            state <= S_SETTLE;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            cnt       <= '0;
            pll_reset <= 1'b1;
            retry     <= retry + RW'(1);
            if (retry >= RW'(MAX_RETRY - 1)) begin
              err         <= 1'b1;
              req_if.busy <= 1'b0;
              state       <= S_FAULT;
            end else begin
              state <= S_PLLRST;
            end
          end
        end
        S_SETTLE: begin
          if (!lk_s) begin
            cnt   <= '0;
            state <= S_WAIT_LOCK;
          end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt     <= '0;
            mux_sel <= target;
            state   <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          if (cnt == CW'(SWITCH_CYCLES - 1)) begin
            clk_en      <= 1'b1;
            cur_sel     <= target;
            req_if.ack  <= ack_en;
            req_if.busy <= 1'b0;
            retry       <= '0;
            state       <= S_ENABLE;
          end
        end
        S_ENABLE: state <= S_IDLE;
        S_FAULT: begin
          if (req_if.req) begin
            if (req_if.req_sel == 2'd3) begin
              req_if.nack <= 1'b1;
            end else begin
              target      <= req_if.req_sel;
              ack_en      <= 1'b1;
              req_if.busy <= 1'b1;
              err         <= 1'b0;
              retry       <= '0;
              cnt         <= '0;
              state       <= S_PLLRST;
            end
          end
        end
        default: state <= S_PLLRST;
      endcase
    end
  end

endmodule

// File: tb/tb_clkgen_freq_ctrl.sv
// Bench for clkgen_freq_ctrl: directed scenarios plus randomized requests,
// scored against a PLL model and request-level latency rules.
module tb_clkgen_freq_ctrl;
  localparam int RST    = 16;
  localparam int TMO    = 4096;
  localparam int SETTLE = 64;
  localparam int L      = 100;

  logic       clk_in  = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] cur_sel, mux_sel;
  logic       clk_en, pll_reset, err, lock_lost, pll_locked;

  clkgen_freq_ctrl_if bus ();

  clkgen_freq_ctrl dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .req_if     (bus),
    .cur_sel    (cur_sel),
    .mux_sel    (mux_sel),
    .clk_en     (clk_en),
    .pll_reset  (pll_reset),
    .pll_locked (pll_locked),
    .err        (err),
    .lock_lost  (lock_lost)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_in) cyc++;

  // PLL model: locks lock_lat cycles after its reset is released.
  int lock_lat  = L;
  int pll_cnt   = 0;
  bit lock_ok   = 1'b1;
  bit force_low = 1'b0;
  always @(posedge clk_in) begin
    #1;
    if (pll_reset) pll_cnt = 0;
    else if (pll_cnt < 1000000) pll_cnt++;
  end
  assign pll_locked = lock_ok && !force_low && (pll_cnt >= lock_lat);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int         ack_cnt  = 0;
  int         nack_cnt = 0;
  logic [1:0] prev_mux = 2'd0;
  always @(negedge clk_in) begin
    if (bus.ack === 1'b1) ack_cnt++;
    if (bus.nack === 1'b1) nack_cnt++;
    if (mux_sel !== prev_mux) check("mux_change_gated", clk_en, 1'b0);
    if (bus.ack === 1'b1) check("ack_with_clk_en", clk_en, 1'b1);
    prev_mux = mux_sel;
  end

  task automatic present_req(input logic [1:0] sel, output int r);
    @(negedge clk_in);
    bus.req_sel = sel;
    bus.req     = 1'b1;
    r           = cyc;
    @(posedge clk_in);
    #1 bus.req = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output int at, output bit got_nack);
    at = -1;
    got_nack = 1'b0;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk_in);
      if (bus.ack === 1'b1 || bus.nack === 1'b1) begin
        at = cyc;
        got_nack = (bus.nack === 1'b1);
      end
    end
  endtask

  task automatic wait_clk_en(input logic lvl, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk_in);
      if (clk_en === lvl) at = cyc;
    end
  endtask

  task automatic wait_pll_reset(input logic lvl, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk_in);
      if (pll_reset === lvl) at = cyc;
    end
  endtask

  initial begin
    int r, at, at2, fall_cyc, hi_cyc, a0, n0, n_hi, falls, run, exp_lat;
    bit got_nack;
    logic prev;
    logic [1:0] sel, m_cur;
    int high_runs[$];
    int low_runs[$];

    bus.req = 1'b0;
    bus.req_sel = 2'd0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_pll_reset", pll_reset, 1'b1);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_clk_en", clk_en, 1'b0);
    check("rst_ack_nack", {bus.ack, bus.nack}, 2'b00);
    check("rst_err_lost", {err, lock_lost}, 2'b00);
    check("rst_sels", {mux_sel, cur_sel}, 4'h0);

    // Boot
    @(posedge clk_in);
    #1 reset_n = 1'b1;
    n_hi = 0;
    fall_cyc = -1;
    for (int i = 0; i < 200 && fall_cyc < 0; i++) begin
      @(negedge clk_in);
      if (pll_reset === 1'b1) n_hi++;
      else fall_cyc = cyc;
    end
    check("boot_rst_high", n_hi, RST);
    wait_clk_en(1'b1, 400, at);
    check("boot_enable_cycle", at - fall_cyc, L + 2 + SETTLE + 2);
    check("boot_busy", bus.busy, 1'b0);
    check("boot_sels", {mux_sel, cur_sel}, 4'h0);
    check("boot_no_ack", ack_cnt, 0);

    // Change 0 -> 2
    @(negedge clk_in);
    a0 = ack_cnt;
    present_req(2'd2, r);
    @(negedge clk_in);
    check("chg_busy", bus.busy, 1'b1);
    check("chg_gated", clk_en, 1'b0);
    wait_resp(400, at, got_nack);
    check("chg_latency", at - r + 1, 1 + 4 + RST + L + 2 + SETTLE + 2 + 1);
    check("chg_sels", {mux_sel, cur_sel}, 4'b1010);
    @(negedge clk_in);
    check("chg_single_ack", ack_cnt - a0, 1);
    check("chg_idle_busy", bus.busy, 1'b0);

    // Fast path
    present_req(2'd2, r);
    @(negedge clk_in);
    check("fast_ack", bus.ack, 1'b1);
    check("fast_clk_en", clk_en, 1'b1);
    @(negedge clk_in);
    check("fast_ack_once", bus.ack, 1'b0);
    check("fast_clk_en_held", clk_en, 1'b1);

    // Invalid select
    a0 = ack_cnt;
    present_req(2'd3, r);
    @(negedge clk_in);
    check("inv_nack", bus.nack, 1'b1);
    check("inv_outputs", {clk_en, bus.busy, mux_sel, cur_sel}, 6'b10_1010);
    @(negedge clk_in);
    check("inv_nack_once", bus.nack, 1'b0);
    check("inv_no_ack", ack_cnt - a0, 0);

    // Lock glitch in IDLE, then a drop during SETTLE
    check("glitch_lost_before", lock_lost, 1'b0);
    a0 = ack_cnt;
    @(negedge clk_in);
    force_low = 1'b1;
    repeat (5) @(negedge clk_in);
    force_low = 1'b0;
    wait_clk_en(1'b0, 20, at);
    check("glitch_gate_drop", clk_en, 1'b0);
    check("glitch_lost_busy", {lock_lost, bus.busy}, 2'b11);
    wait_pll_reset(1'b0, 100, fall_cyc);
    repeat (L + 12) @(negedge clk_in);
    force_low = 1'b1;
    repeat (20) @(negedge clk_in);
    force_low = 1'b0;
    hi_cyc = cyc;
    wait_clk_en(1'b1, 400, at);
    check("glitch_settle_restart", at - hi_cyc, 2 + SETTLE + 2 + 1);
    check("glitch_sels", {mux_sel, cur_sel}, 4'b1010);
    check("glitch_no_ack", ack_cnt - a0, 0);
    check("glitch_lost_sticky", lock_lost, 1'b1);

    // Reset in the middle of WAIT_LOCK during a change to 1
    present_req(2'd1, r);
    wait_pll_reset(1'b1, 50, at);
    wait_pll_reset(1'b0, 50, at);
    repeat (50) @(negedge clk_in);
    a0 = ack_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_pll_reset", pll_reset, 1'b1);
    check("mid_rst_clk_en", clk_en, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b1);
    check("mid_rst_lost", lock_lost, 1'b0);
    repeat (3) @(posedge clk_in);
    #1 reset_n = 1'b1;
    wait_clk_en(1'b1, 400, at);
    check("reboot_sels", {mux_sel, cur_sel}, 4'h0);
    check("reboot_no_ack", ack_cnt - a0, 0);

    // Lock never asserts
    present_req(2'd1, r);
    lock_ok = 1'b0;
    prev = pll_reset;
    run = 0;
    falls = 0;
    for (int i = 0; i < 3 * (RST + TMO) + 100; i++) begin
      @(negedge clk_in);
      if (pll_reset !== prev) begin
        if (prev === 1'b1) begin
          falls++;
          high_runs.push_back(run);
        end else begin
          low_runs.push_back(run);
        end
        run = 1;
        prev = pll_reset;
      end else begin
        run++;
      end
      if (bus.busy === 1'b0) break;
    end
    check("flt_pulses", falls, 3);
    foreach (high_runs[k]) check("flt_rst_high", high_runs[k], RST);
    check("flt_low_runs", low_runs.size(), 4);
    for (int k = 1; k < low_runs.size(); k++) check("flt_wait_len", low_runs[k], TMO);
    check("flt_state", {err, bus.busy, clk_en, pll_reset}, 4'b1001);

    // Recovery from FAULT
    lock_ok = 1'b1;
    a0 = ack_cnt;
    present_req(2'd1, r);
    @(negedge clk_in);
    check("rec_err_clear", {err, bus.busy}, 2'b01);
    wait_resp(400, at, got_nack);
    check("rec_latency", at - r + 1, 1 + RST + L + 2 + SETTLE + 2 + 1);
    check("rec_cur", cur_sel, 2'd1);
    @(negedge clk_in);
    check("rec_single_ack", ack_cnt - a0, 1);

    // Randomized requests against a request-level model
    m_cur = 2'd1;
    for (int k = 0; k < 8; k++) begin
      sel = 2'($urandom_range(0, 3));
      lock_lat = int'($urandom_range(3, 60));
      exp_lat = (sel == 2'd3 || sel == m_cur) ? 2 : 1 + 4 + RST + lock_lat + 2 + SETTLE + 2 + 1;
      a0 = ack_cnt;
      n0 = nack_cnt;
      present_req(sel, r);
      wait_resp(400, at, got_nack);
      check("rnd_latency", at - r + 1, exp_lat);
      check("rnd_kind", got_nack, sel == 2'd3);
      if (sel != 2'd3) m_cur = sel;
      check("rnd_cur", cur_sel, m_cur);
      @(negedge clk_in);
      check("rnd_one_resp", (ack_cnt - a0) + (nack_cnt - n0), 1);
      at2 = int'($urandom_range(1, 5));
      repeat (at2) @(negedge clk_in);
    end
    check("rnd_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
